// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types and helpers for the unified-memory arbiter.
package riscv_mem_arbiter_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_DONE   = 2'd2
   } arb_state_e;

   // Owner of the access currently in flight
   localparam logic ARB_OWNER_I = 1'b0;
   localparam logic ARB_OWNER_D = 1'b1;

   // Latency counter width: holds MEM_LATENCY-1 for latencies up to 7
   localparam int LAT_CNT_W = 3;

   // Width of the fetch-starvation streak counter (STARVE_MAX up to 15)
   localparam int STREAK_W = 4;

   // Saturating increment of the contested-D streak
   function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] streak,
                                                      input logic [STREAK_W-1:0] limit);
      return (streak >= limit) ? limit : streak + {{(STREAK_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/riscv_mem_arbiter_lat_cnt.sv
// Loadable down-counter that flags when the memory read latency has elapsed.
module riscv_arb_lat_cnt
   import riscv_mem_arbiter_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [LAT_CNT_W-1:0] load_val,
   input  logic                 dec,
   output logic                 done
);

   localparam logic [LAT_CNT_W-1:0] CNT_ONE = {{(LAT_CNT_W-1){1'b0}}, 1'b1};

   logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

   // Load has priority; decrement stops at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port unified memory between instruction fetch and load/store.
// One access at a time: grant -> mem_en cycle -> wait MEM_LATENCY -> 1-cycle valid.
// Handshake: a requester holds req and its address/data until its valid; req high in
// the cycle of its own valid is a new request; dropping req after the grant does not
// cancel the access.
module riscv_mem_arbiter
   import riscv_mem_arbiter_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned STARVE_MAX  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   output logic        if_wait,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic        d_wait,
   output logic        mem_en,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [LAT_CNT_W-1:0] LAT_LOAD   = LAT_CNT_W'(MEM_LATENCY - 1);
   localparam logic [STREAK_W-1:0]  STARVE_LIM = STREAK_W'(STARVE_MAX);

   arb_state_e          state_q, state_d;
   logic                owner_q, owner_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [3:0]          mem_be_q, mem_be_d;
   logic [31:0]         mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic [31:0]         if_rdata_q, if_rdata_d;
   logic [31:0]         d_rdata_q, d_rdata_d;
   logic                if_valid_q, if_valid_d;
   logic                d_valid_q, d_valid_d;

   logic can_arb, d_wins, i_wins;
   logic cnt_load, cnt_dec, lat_done;

   riscv_arb_lat_cnt u_lat_cnt (
      .clk      (clk),
      .rst_n    (rst),
      .load     (cnt_load),
      .load_val (LAT_LOAD),
      .dec      (cnt_dec),
      .done     (lat_done)
   );

   // Data wins contention unless fetch has already lost STARVE_MAX contests in a row
   always_comb begin
      can_arb = (state_q == ARB_IDLE) || (state_q == ARB_DONE);
      d_wins  = d_req && (!if_req || (streak_q != STARVE_LIM));
      i_wins  = if_req && !d_wins;
   end

   // Next-state, latched request and registered outputs
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      streak_d    = streak_q;
      mem_en_d    = 1'b0;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_valid_d  = 1'b0;
      d_valid_d   = 1'b0;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;

      // ACCESS: the mem_en cycle loads the counter; read data is taken when it expires
      if (state_q == ARB_ACCESS) begin
         if (mem_en_q) begin
            cnt_load = 1'b1;
         end else if (lat_done) begin
            state_d = ARB_DONE;
            if (owner_q == ARB_OWNER_I) begin
               if_valid_d = 1'b1;
               if_rdata_d = mem_rdata;
            end else begin
               d_valid_d = 1'b1;
               if (!mem_we_q) begin
                  d_rdata_d = mem_rdata;
               end
            end
         end else begin
            cnt_dec = 1'b1;
         end
      end

      // IDLE and DONE both arbitrate, so grants can run back-to-back
      if (can_arb) begin
         state_d = ARB_IDLE;
         if (d_wins) begin
            state_d     = ARB_ACCESS;
            owner_d     = ARB_OWNER_D;
            mem_en_d    = 1'b1;
            mem_we_d    = d_we;
            mem_be_d    = d_be;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (if_req) begin
               streak_d = streak_inc(streak_q, STARVE_LIM);
            end
         end else if (i_wins) begin
            state_d    = ARB_ACCESS;
            owner_d    = ARB_OWNER_I;
            mem_en_d   = 1'b1;
            mem_we_d   = 1'b0;
            mem_be_d   = 4'b0000;
            mem_addr_d = if_addr;
            streak_d   = '0;
         end
      end
   end

   // State and output registers; reset abandons any access in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ARB_IDLE;
         owner_q     <= ARB_OWNER_I;
         streak_q    <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 4'b0000;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_valid_q  <= 1'b0;
         d_valid_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         streak_q    <= streak_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_valid_q  <= if_valid_d;
         d_valid_q   <= d_valid_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign if_valid  = if_valid_q;
   assign d_rdata   = d_rdata_q;
   assign d_valid   = d_valid_q;
   assign if_wait   = if_req & ~if_valid_q;
   assign d_wait    = d_req & ~d_valid_q;

endmodule
